// File: rtl/fft_pkg.sv
// Shared constants for the R22SDF twiddle multiplier: rounding mode selectors and pipeline depth.
package fft_pkg;

    localparam int ROUND_TRUNC  = 0;
    localparam int ROUND_CONV   = 1;
    localparam int CMUL_LATENCY = 5;

endpackage : fft_pkg

// File: rtl/fft_round_sat.sv
// Combinational scale-by-2^-SHIFT with floor or round-half-to-even, followed by saturation.
module fft_round_sat
    import fft_pkg::*;
#(
    parameter int IN_WIDTH   = 36,
    parameter int SHIFT      = 9,
    parameter int OUT_WIDTH  = 25,
    parameter int ROUND_MODE = ROUND_CONV
) (
    input  logic signed [IN_WIDTH-1:0]  value_i,
    output logic signed [OUT_WIDTH-1:0] value_o,
    output logic                        clamp_o
);

    // One extra bit above the shifted value so the round-up increment can never wrap.
    localparam int QW = IN_WIDTH - SHIFT + 1;
    localparam logic [SHIFT-1:0]     HALF = {1'b1, {(SHIFT-1){1'b0}}};
    localparam logic signed [QW-1:0] MAXV = {{(QW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [QW-1:0] MINV = {{(QW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    logic signed [QW-1:0] quot;
    logic signed [QW-1:0] rounded;
    logic [SHIFT-1:0]     frac;
    logic                 roundUp;
    logic                 overHigh;
    logic                 underLow;

    assign quot     = {value_i[IN_WIDTH-1], value_i[IN_WIDTH-1:SHIFT]};
    assign frac     = value_i[SHIFT-1:0];
    assign roundUp  = (ROUND_MODE == ROUND_CONV) &&
                      ((frac > HALF) || ((frac == HALF) && quot[0]));
    assign rounded  = quot + {{(QW-1){1'b0}}, roundUp};
    assign overHigh = rounded > MAXV;
    assign underLow = rounded < MINV;

    assign clamp_o  = overHigh || underLow;
    assign value_o  = overHigh ? MAXV[OUT_WIDTH-1:0] :
                      underLow ? MINV[OUT_WIDTH-1:0] : rounded[OUT_WIDTH-1:0];

endmodule : fft_round_sat

// File: rtl/fft_r22sdf_cmul.sv
// Five-stage pipelined complex twiddle multiplier (3-multiply Karatsuba) with rounding,
// saturation, sticky overflow and per-frame twiddle conjugation for inverse transforms.
module fft_r22sdf_cmul
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH    = 25,
    parameter int TWIDDLE_WIDTH = 10,
    parameter int NLOG2         = 10,
    parameter int ROUND_MODE    = ROUND_CONV
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         valid_i,
    input  logic [NLOG2-1:0]             ctr_i,
    input  logic                         inv_i,
    input  logic signed [DATA_WIDTH-1:0] x_re_i,
    input  logic signed [DATA_WIDTH-1:0] x_im_i,
    input  logic signed [TWIDDLE_WIDTH-1:0] w_re_i,
    input  logic signed [TWIDDLE_WIDTH-1:0] w_im_i,
    input  logic                         ovf_clr_i,
    output logic                         valid_o,
    output logic [NLOG2-1:0]             ctr_o,
    output logic signed [DATA_WIDTH-1:0] z_re_o,
    output logic signed [DATA_WIDTH-1:0] z_im_o,
    output logic                         ovf_o
);

    localparam int DW = DATA_WIDTH;
    localparam int TW = TWIDDLE_WIDTH;
    localparam int PW = DW + TW + 2;

    logic                 inv_q;
    logic [3:0]           vPipe_q;
    logic [3:0][NLOG2-1:0] ctrPipe_q;

    logic signed [DW-1:0] a1_q, b1_q, a2_q, b2_q;
    logic signed [TW:0]   c1_q, d1_q, c2_q;
    logic signed [DW:0]   e2_q;
    logic signed [TW+1:0] s2_q, t2_q;
    logic signed [PW-1:0] f3_q, p13_q, p23_q;
    logic signed [PW-1:0] re4_q, im4_q;

    logic                 valid_q, ovf_q;
    logic [NLOG2-1:0]     ctr_q;
    logic signed [DW-1:0] zRe_q, zIm_q;

    logic                 invEff;
    logic signed [TW:0]   wImExt;
    logic signed [TW:0]   d1_d;
    logic signed [DW-1:0] zRe_d, zIm_d;
    logic                 clampRe, clampIm;

    // The frame-start sample must already see its own inv_i, so bypass the mode register.
    assign invEff = (valid_i && (ctr_i == '0)) ? inv_i : inv_q;
    assign wImExt = {w_im_i[TW-1], w_im_i};
    assign d1_d   = invEff ? -wImExt : wImExt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            inv_q     <= 1'b0;
            vPipe_q   <= '0;
            ctrPipe_q <= '0;
            a1_q  <= '0;  b1_q  <= '0;  c1_q <= '0;  d1_q <= '0;
            a2_q  <= '0;  b2_q  <= '0;  c2_q <= '0;
            e2_q  <= '0;  s2_q  <= '0;  t2_q <= '0;
            f3_q  <= '0;  p13_q <= '0;  p23_q <= '0;
            re4_q <= '0;  im4_q <= '0;
        end else begin
            if (valid_i && (ctr_i == '0)) begin
                inv_q <= inv_i;
            end
            vPipe_q   <= {vPipe_q[2:0], valid_i};
            ctrPipe_q <= {ctrPipe_q[2:0], ctr_i};

            a1_q <= x_re_i;
            b1_q <= x_im_i;
            c1_q <= {w_re_i[TW-1], w_re_i};
            d1_q <= d1_d;

            a2_q <= a1_q;
            b2_q <= b1_q;
            c2_q <= c1_q;
            e2_q <= {a1_q[DW-1], a1_q} - {b1_q[DW-1], b1_q};
            s2_q <= {c1_q[TW], c1_q} - {d1_q[TW], d1_q};
            t2_q <= {c1_q[TW], c1_q} + {d1_q[TW], d1_q};

            f3_q  <= PW'(c2_q) * PW'(e2_q);
            p13_q <= PW'(b2_q) * PW'(s2_q);
            p23_q <= PW'(a2_q) * PW'(t2_q);

            re4_q <= p13_q + f3_q;
            im4_q <= p23_q - f3_q;
        end
    end

    fft_round_sat #(
        .IN_WIDTH  (PW),
        .SHIFT     (TW - 1),
        .OUT_WIDTH (DW),
        .ROUND_MODE(ROUND_MODE)
    ) u_round_re (
        .value_i(re4_q),
        .value_o(zRe_d),
        .clamp_o(clampRe)
    );

    fft_round_sat #(
        .IN_WIDTH  (PW),
        .SHIFT     (TW - 1),
        .OUT_WIDTH (DW),
        .ROUND_MODE(ROUND_MODE)
    ) u_round_im (
        .value_i(im4_q),
        .value_o(zIm_d),
        .clamp_o(clampIm)
    );

    // Outputs hold across bubbles; a new clamp outranks a coincident clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            ctr_q   <= '0;
            zRe_q   <= '0;
            zIm_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            valid_q <= vPipe_q[3];
            if (vPipe_q[3]) begin
                ctr_q <= ctrPipe_q[3];
                zRe_q <= zRe_d;
                zIm_q <= zIm_d;
            end
            if (vPipe_q[3] && (clampRe || clampIm)) begin
                ovf_q <= 1'b1;
            end else if (ovf_clr_i) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign valid_o = valid_q;
    assign ctr_o   = ctr_q;
    assign z_re_o  = zRe_q;
    assign z_im_o  = zIm_q;
    assign ovf_o   = ovf_q;

endmodule : fft_r22sdf_cmul

// File: tb/tb_fft_r22sdf_cmul.sv
// Scoreboard bench: convergent and truncating instances share stimulus; expectations come
// from exact integer complex arithmetic followed by floor/half-even division and clamping.
module tb_fft_r22sdf_cmul;

    localparam int DW  = 16;
    localparam int TW  = 10;
    localparam int NL  = 10;
    localparam int LAT = 5;

    logic clk = 1'b0;
    logic rst;
    logic valid_i, inv_i, ovf_clr_i;
    logic [NL-1:0] ctr_i;
    logic signed [DW-1:0] xRe, xIm;
    logic signed [TW-1:0] wRe, wIm;

    logic validC, ovfC, validT, ovfT;
    logic [NL-1:0] ctrC, ctrT;
    logic signed [DW-1:0] zReC, zImC, zReT, zImT;

    typedef struct {
        int ctr;
        int re;
        int im;
        int stamp;
    } exp_t;

    exp_t qConv[$];
    exp_t qTrunc[$];
    int   nChecks = 0;
    int   nFail   = 0;
    int   cycle   = 0;
    bit   invModel = 1'b0;

    fft_r22sdf_cmul #(.DATA_WIDTH(DW), .TWIDDLE_WIDTH(TW), .NLOG2(NL), .ROUND_MODE(1)) dutConv (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ctr_i(ctr_i), .inv_i(inv_i),
        .x_re_i(xRe), .x_im_i(xIm), .w_re_i(wRe), .w_im_i(wIm), .ovf_clr_i(ovf_clr_i),
        .valid_o(validC), .ctr_o(ctrC), .z_re_o(zReC), .z_im_o(zImC), .ovf_o(ovfC)
    );

    fft_r22sdf_cmul #(.DATA_WIDTH(DW), .TWIDDLE_WIDTH(TW), .NLOG2(NL), .ROUND_MODE(0)) dutTrunc (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ctr_i(ctr_i), .inv_i(inv_i),
        .x_re_i(xRe), .x_im_i(xIm), .w_re_i(wRe), .w_im_i(wIm), .ovf_clr_i(ovf_clr_i),
        .valid_o(validT), .ctr_o(ctrT), .z_re_o(zReT), .z_im_o(zImT), .ovf_o(ovfT)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkEq(input string name, input longint act, input longint exp);
        nChecks++;
        if (act != exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Divide by 2^(TW-1) exactly as real arithmetic would, then round and clamp.
    function automatic int scaleRound(input longint r, input bit conv);
        longint q, rem;
        q   = r / 512;
        rem = r - q * 512;
        if (rem < 0) begin
            q   = q - 1;
            rem = rem + 512;
        end
        if (conv && ((rem > 256) || ((rem == 256) && ((q % 2) != 0)))) q = q + 1;
        if (q > 32767)  q = 32767;
        if (q < -32768) q = -32768;
        return int'(q);
    endfunction

    task automatic driveInputs(input int ctr, input bit inv, input int xr, input int xi,
                               input int wr, input int wi);
        @(negedge clk);
        valid_i = 1'b1;
        ctr_i   = NL'(ctr);
        inv_i   = inv;
        xRe     = DW'(xr);
        xIm     = DW'(xi);
        wRe     = TW'(wr);
        wIm     = TW'(wi);
        if (ctr == 0) invModel = inv;
    endtask

    task automatic applyStimulus(input int ctr, input bit inv, input int xr, input int xi,
                                 input int wr, input int wi);
        longint wiEff, rr, ii;
        exp_t   e;
        driveInputs(ctr, inv, xr, xi, wr, wi);
        wiEff   = invModel ? -longint'(wi) : longint'(wi);
        rr      = longint'(xr) * wr - longint'(xi) * wiEff;
        ii      = longint'(xr) * wiEff + longint'(xi) * wr;
        e.ctr   = ctr;
        e.stamp = cycle;
        e.re    = scaleRound(rr, 1'b1);
        e.im    = scaleRound(ii, 1'b1);
        qConv.push_back(e);
        e.re    = scaleRound(rr, 1'b0);
        e.im    = scaleRound(ii, 1'b0);
        qTrunc.push_back(e);
    endtask

    task automatic applyDirected(input int ctr, input bit inv, input int xr, input int xi,
                                 input int wr, input int wi, input int cRe, input int cIm,
                                 input int tRe, input int tIm);
        exp_t e;
        driveInputs(ctr, inv, xr, xi, wr, wi);
        e.ctr   = ctr;
        e.stamp = cycle;
        e.re    = cRe;
        e.im    = cIm;
        qConv.push_back(e);
        e.re    = tRe;
        e.im    = tIm;
        qTrunc.push_back(e);
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(negedge clk);
            valid_i = 1'b0;
            ctr_i   = NL'($urandom);
            inv_i   = 1'($urandom);
            xRe     = DW'($urandom);
            xIm     = DW'($urandom);
            wRe     = TW'($urandom);
            wIm     = TW'($urandom);
        end
    endtask

    task automatic waitDrain();
        int n = 0;
        while (((qConv.size() != 0) || (qTrunc.size() != 0)) && (n < 50)) begin
            idleCycles(1);
            n++;
        end
        checkEq("pending outputs after drain", qConv.size() + qTrunc.size(), 0);
        qConv.delete();
        qTrunc.delete();
    endtask

    task automatic checkOutput(input string tag, input exp_t e, input int ctr,
                               input int re, input int im);
        checkEq({tag, " ctr_o"}, ctr, e.ctr);
        checkEq({tag, " z_re_o"}, re, e.re);
        checkEq({tag, " z_im_o"}, im, e.im);
        checkEq({tag, " latency"}, cycle - e.stamp, LAT);
    endtask

    always @(negedge clk) begin
        if (!rst && validC) begin
            if (qConv.size() == 0) checkEq("conv unexpected valid_o", 1, 0);
            else checkOutput("conv", qConv.pop_front(), int'(ctrC), int'(zReC), int'(zImC));
        end
    end

    always @(negedge clk) begin
        if (!rst && validT) begin
            if (qTrunc.size() == 0) checkEq("trunc unexpected valid_o", 1, 0);
            else checkOutput("trunc", qTrunc.pop_front(), int'(ctrT), int'(zReT), int'(zImT));
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        int stale;
        bit invF;
        rst = 1'b1; valid_i = 1'b0; inv_i = 1'b0; ovf_clr_i = 1'b0;
        ctr_i = '0; xRe = '0; xIm = '0; wRe = '0; wIm = '0;
        repeat (3) @(negedge clk);
        checkEq("reset valid_o", validC, 0);
        checkEq("reset z_re_o", zReC, 0);
        checkEq("reset z_im_o", zImC, 0);
        checkEq("reset ctr_o", ctrC, 0);
        checkEq("reset ovf_o", ovfC, 0);
        @(negedge clk);
        rst = 1'b0;

        applyDirected(5, 0, 1000, 0, 511, 0, 998, 0, 998, 0);
        waitDrain();

        // Conjugation is latched only at frame start; mid-frame inv_i changes are ignored.
        applyDirected(0, 0, 1000, 2000, 0, -512, 2000, -1000, 2000, -1000);
        applyDirected(1, 1, 1000, 2000, 0, -512, 2000, -1000, 2000, -1000);
        applyDirected(0, 1, 1000, 2000, 0, -512, -2000, 1000, -2000, 1000);
        applyDirected(1, 0, 1000, 2000, 0, -512, -2000, 1000, -2000, 1000);
        waitDrain();

        applyDirected(2, 0, 1, 0, 256, 0, 0, 0, 0, 0);
        applyDirected(3, 0, 3, 0, 256, 0, 2, 0, 1, 0);
        applyDirected(4, 0, -3, 0, 256, 0, -2, 0, -2, 0);
        applyDirected(5, 0, 0, 3, 256, 0, 0, 2, 0, 1);
        waitDrain();

        checkEq("ovf_o before clamp", ovfC, 0);
        applyDirected(0, 0, 32767, 32767, 362, 362, 0, 32767, 0, 32767);
        idleCycles(4);
        checkEq("ovf_o one cycle early", ovfC, 0);
        idleCycles(1);
        checkEq("ovf_o after clamp", ovfC, 1);
        waitDrain();
        @(negedge clk) ovf_clr_i = 1'b1;
        @(negedge clk) ovf_clr_i = 1'b0;
        checkEq("ovf_o after clear", ovfC, 0);

        applyDirected(1, 0, 32767, 32767, 362, 362, 0, 32767, 0, 32767);
        idleCycles(3);
        @(negedge clk);
        valid_i   = 1'b0;
        ovf_clr_i = 1'b1;
        @(negedge clk);
        ovf_clr_i = 1'b0;
        checkEq("ovf_o set beats clear", ovfC, 1);

        applyDirected(2, 0, -32768, -32768, 362, -362, -32768, 0, -32768, 0);
        waitDrain();
        @(negedge clk) ovf_clr_i = 1'b1;
        @(negedge clk) ovf_clr_i = 1'b0;

        for (int frame = 0; frame < 2; frame++) begin
            invF = (frame == 0) ? 1'($urandom) : ~invModel;
            for (int k = 0; k < 1024; k++) begin
                if ($urandom_range(3) == 0) idleCycles($urandom_range(1, 2));
                applyStimulus(k, (k == 0) ? invF : 1'($urandom),
                              int'($urandom_range(65535)) - 32768,
                              int'($urandom_range(65535)) - 32768,
                              int'($urandom_range(1023)) - 512,
                              int'($urandom_range(1023)) - 512);
            end
        end
        waitDrain();

        // Reset with three samples in flight: they must vanish and outputs clear at once.
        applyStimulus(5, 0, 1234, -567, 300, -200);
        applyStimulus(6, 0, -4321, 765, -100, 400);
        applyStimulus(7, 0, 999, 888, 511, 511);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkEq("mid reset valid_o", validC, 0);
        checkEq("mid reset z_re_o", zReC, 0);
        checkEq("mid reset z_im_o", zImC, 0);
        checkEq("mid reset ctr_o", ctrC, 0);
        checkEq("mid reset ovf_o", ovfC, 0);
        checkEq("mid reset trunc valid_o", validT, 0);
        qConv.delete();
        qTrunc.delete();
        valid_i  = 1'b0;
        invModel = 1'b0;
        repeat (2) @(negedge clk);
        rst   = 1'b0;
        stale = 0;
        repeat (10) begin
            @(negedge clk);
            if (validC || validT) stale++;
        end
        checkEq("stale valid_o after reset", stale, 0);
        applyStimulus(3, 1, 20000, -15000, 400, -300);
        waitDrain();

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
        $finish;
    end

endmodule : tb_fft_r22sdf_cmul
